branch_predictor: RTL

Parametrised branch predictor for the pipelined RISC-V CPU fetch stage. It combines a direct-mapped branch target buffer (BTB) with 2-bit saturating direction counters. Fetch looks it up combinationally every cycle; the execute stage updates it on resolved branches. It also keeps wrapping performance counters for resolved and mispredicted branches. With MODE=0 it degrades to the current static not-taken behaviour, where taken branches flush fetch/decode.

---
 rtl/branch_predictor.sv | 97 +++++++++
 1 files changed

// File: rtl/branch_predictor.sv
// Fetch-stage branch predictor: direct-mapped BTB with 2-bit direction counters,
// updated from execute, plus wrapping resolved/mispredicted branch counters.
module branch_predictor #(
  parameter int unsigned ENTRIES = 16,
  parameter int unsigned MODE    = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] f_pc,
  output logic        f_pred_taken,
  output logic [31:0] f_pred_target,
  input  logic        e_valid,
  input  logic [31:0] e_pc,
  input  logic        e_taken,
  input  logic [31:0] e_target,
  input  logic        e_pred_taken,
  input  logic [31:0] e_pred_target,
  output logic        e_mispredict,
  output logic [31:0] n_branches,
  output logic [31:0] n_mispredicts
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);
  localparam int unsigned TAG_W = 32 - IDX_W - 2;
  localparam logic        BTB_ON = (MODE != 0);

  logic [ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [31:0]        target_q [ENTRIES];
  logic [1:0]         ctr_q    [ENTRIES];

  logic [IDX_W-1:0] f_idx, e_idx;
  logic [TAG_W-1:0] f_tag, e_tag;
  logic             f_hit, e_hit;
  logic [1:0]       e_ctr, ctr_next;
  logic             tbl_we;

  // Word-aligned instructions: the low PC bits carry no information.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{f_pc[1:0], e_pc[1:0]};

  assign f_idx = f_pc[IDX_W+1:2];
  assign f_tag = f_pc[31:IDX_W+2];
  assign e_idx = e_pc[IDX_W+1:2];
  assign e_tag = e_pc[31:IDX_W+2];

  // Zero-latency lookup; no bypass from a same-cycle update.
  always_comb begin
    f_hit         = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
    f_pred_taken  = BTB_ON && f_hit && ctr_q[f_idx][1];
    f_pred_target = f_pred_taken ? target_q[f_idx] : f_pc + 32'd4;
  end

  assign e_mispredict = e_valid &&
                        ((e_taken != e_pred_taken) ||
                         (e_taken && (e_target != e_pred_target)));

  // Saturating direction counter update for the resolved entry.
  always_comb begin
    e_hit    = valid_q[e_idx] && (tag_q[e_idx] == e_tag);
    e_ctr    = ctr_q[e_idx];
    ctr_next = e_ctr;
    if (e_taken) begin
      if (e_ctr != 2'b11) ctr_next = e_ctr + 2'd1;
    end else begin
      if (e_ctr != 2'b00) ctr_next = e_ctr - 2'd1;
    end
    tbl_we = BTB_ON && e_valid && !rst;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q       <= '0;
      n_branches    <= 32'd0;
      n_mispredicts <= 32'd0;
    end else if (e_valid) begin
      n_branches    <= n_branches + 32'd1;
      n_mispredicts <= n_mispredicts + 32'(e_mispredict);
      if (BTB_ON && !e_hit && e_taken) valid_q[e_idx] <= 1'b1;
    end
  end

  // Payload fields are qualified by valid and need no reset.
  always_ff @(posedge clk) begin
    if (tbl_we) begin
      if (e_hit) begin
        ctr_q[e_idx] <= ctr_next;
        if (e_taken) target_q[e_idx] <= e_target;
      end else if (e_taken) begin
        tag_q[e_idx]    <= e_tag;
        target_q[e_idx] <= e_target;
        ctr_q[e_idx]    <= 2'b10;
      end
    end
  end

endmodule
